// File: rtl/serial_alu_seq_if.sv
// serial_alu_seq_if: groups the CPU-side handshake and the 1-bit slice bus of the bit-serial ALU sequencer.
//   master : CPU/slice side -> drives start, op, a, b, s_y, s_cout; observes busy, done, result, carry_out, s_a, s_b, s_cin, s_op
//   slave  : the sequencer   -> the opposite directions
interface serial_alu_seq_if #(parameter int WIDTH = 8);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             s_a;
   logic             s_b;
   logic             s_cin;
   logic [2:0]       s_op;
   logic             s_y;
   logic             s_cout;
   modport master (output start, op, a, b, s_y, s_cout,
                   input  busy, done, result, carry_out, s_a, s_b, s_cin, s_op);
   modport slave  (input  start, op, a, b, s_y, s_cout,
                   output busy, done, result, carry_out, s_a, s_b, s_cin, s_op);
endinterface

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial ALU sequencer; latches a WIDTH-bit op on start, feeds a 1-bit slice LSB first, collects result and final carry.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave modport carrying start/op/a/b, busy/done/result/carry_out and the slice bus s_a/s_b/s_cin/s_op/s_y/s_cout
module serial_alu_seq #(parameter int WIDTH = 8) (
   input logic              clk,
   input logic              rst,
   serial_alu_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_result;
   logic [2:0]       r_op;
   logic             r_carry, r_carry_out;
   logic [CW-1:0]    r_cnt;
   logic             w_accept, w_last, w_run;
   assign w_run    = r_state == RUN;
   assign w_accept = bus.start && !w_run;
   assign w_last   = r_cnt == CW'(WIDTH - 1);
   always_ff @(posedge clk)
      r_state <= rst ? IDLE : w_next;
   always_comb begin
      w_next        = w_accept ? RUN : w_run ? (w_last ? DONE : RUN) : IDLE;
      bus.busy      = w_run;
      bus.done      = r_state == DONE;
      bus.s_a       = w_run & r_a[0];
      bus.s_b       = w_run & r_b[0];
      bus.s_cin     = w_run & r_carry;
      bus.s_op      = w_run ? r_op : 3'b000;
      bus.result    = r_result;
      bus.carry_out = r_carry_out;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
      end else if (w_accept) begin
         r_a         <= bus.a;
         r_b         <= bus.b;
         r_op        <= bus.op;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
      end else if (w_run) begin
         r_result <= {bus.s_y, r_result[WIDTH-1:1]};
         r_carry  <= bus.s_cout;
         r_a      <= r_a >> 1;
         r_b      <= r_b >> 1;
         r_cnt    <= r_cnt + CW'(1);
         // carry out is only meaningful for ADD; captured on the edge that completes the MSB
         if (w_last) r_carry_out <= (r_op == 3'b000) & bus.s_cout;
      end
   end
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: directed self-checking bench for serial_alu_seq with a behavioural 1-bit slice.
module tb_serial_alu_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   serial_alu_seq_if #(.WIDTH(8)) bus ();
   serial_alu_seq #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always_comb begin
      bus.s_y    = 1'b0;
      bus.s_cout = 1'b0;
      case (bus.s_op)
         3'b000: begin
            bus.s_y    = bus.s_a ^ bus.s_b ^ bus.s_cin;
            bus.s_cout = (bus.s_a & bus.s_b) | (bus.s_cin & (bus.s_a ^ bus.s_b));
         end
         3'b010: bus.s_y = bus.s_a & bus.s_b;
         3'b011: bus.s_y = bus.s_a | bus.s_b;
         3'b100: bus.s_y = bus.s_a ^ bus.s_b;
         3'b101: bus.s_y = ~bus.s_a;
         default: bus.s_y = 1'b0;
      endcase
   end

   task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_r, input logic exp_c, input logic [7:0] exp_cin, input bit chk_cin,
                         input int poke);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.op = ~op; bus.a = ~a; bus.b = ~b;
      checks++;
      if (bus.result !== 8'h00 || bus.carry_out !== 1'b0)
         begin errors++; $display("FAIL %s clear: result=%h carry=%b, want 00/0", name, bus.result, bus.carry_out); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (bus.busy !== 1'b1 || bus.done !== 1'b0)
            begin errors++; $display("FAIL %s run%0d busy/done=%b%b, want 10", name, i, bus.busy, bus.done); end
         checks++;
         if (bus.s_op !== op || bus.s_a !== a[i] || bus.s_b !== b[i])
            begin errors++; $display("FAIL %s run%0d s_op/s_a/s_b=%b/%b/%b, want %b/%b/%b", name, i, bus.s_op, bus.s_a, bus.s_b, op, a[i], b[i]); end
         if (chk_cin) begin
            checks++;
            if (bus.s_cin !== exp_cin[i])
               begin errors++; $display("FAIL %s run%0d s_cin=%b, want %b", name, i, bus.s_cin, exp_cin[i]); end
         end
         bus.start = (i == poke);
         if (i == poke) begin bus.op = 3'b000; bus.a = 8'hFF; bus.b = 8'hFF; end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0)
         begin errors++; $display("FAIL %s done/busy=%b%b, want 10", name, bus.done, bus.busy); end
      checks++;
      if (bus.result !== exp_r || bus.carry_out !== exp_c)
         begin errors++; $display("FAIL %s result=%h carry=%b, want %h/%b", name, bus.result, bus.carry_out, exp_r, exp_c); end
      checks++;
      if ({bus.s_a, bus.s_b, bus.s_cin, bus.s_op} !== 6'b0)
         begin errors++; $display("FAIL %s slice idle=%b%b%b%b, want zeros", name, bus.s_a, bus.s_b, bus.s_cin, bus.s_op); end
   endtask

   task automatic idle_hold(input string name, input logic [7:0] exp_r, input logic exp_c, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== exp_r || bus.carry_out !== exp_c)
            begin errors++; $display("FAIL %s idle%0d done=%b busy=%b result=%h carry=%b, want 0/0/%h/%b", name, i, bus.done, bus.busy, bus.result, bus.carry_out, exp_r, exp_c); end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.op = 3'b000; bus.a = 8'h00; bus.b = 8'h00;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.carry_out, bus.result} !== 11'b0 || {bus.s_a, bus.s_b, bus.s_cin, bus.s_op} !== 6'b0)
         begin errors++; $display("FAIL reset busy=%b done=%b carry=%b result=%h s_op=%b, want all 0", bus.busy, bus.done, bus.carry_out, bus.result, bus.s_op); end
      rst = 1'b0;
   endtask

   task automatic test_add();
      run_op("add_3c_0a", 3'b000, 8'h3C, 8'h0A, 8'h46, 1'b0, 8'b0111_0000, 1'b1, -1);
      idle_hold("add_3c_0a_hold", 8'h46, 1'b0, 2);
      run_op("add_ff_01", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 8'hFE, 1'b1, -1);
      idle_hold("add_ff_01_hold", 8'h00, 1'b1, 1);
   endtask

   task automatic test_logic();
      run_op("or_f0_0f", 3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0, 8'h00, 1'b1, -1);
      idle_hold("or_hold", 8'hFF, 1'b0, 1);
      run_op("and_cc_aa", 3'b010, 8'hCC, 8'hAA, 8'h88, 1'b0, 8'h00, 1'b1, -1);
      idle_hold("and_hold", 8'h88, 1'b0, 1);
      run_op("xor_cc_aa", 3'b100, 8'hCC, 8'hAA, 8'h66, 1'b0, 8'h00, 1'b1, -1);
      idle_hold("xor_hold", 8'h66, 1'b0, 1);
      run_op("not_cc", 3'b101, 8'hCC, 8'hAA, 8'h33, 1'b0, 8'h00, 1'b1, -1);
      idle_hold("not_hold", 8'h33, 1'b0, 1);
      run_op("undef_110", 3'b110, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, -1);
      idle_hold("undef_hold", 8'h00, 1'b0, 1);
   endtask

   task automatic test_ignore_start();
      run_op("ignore_start", 3'b000, 8'h3C, 8'h0A, 8'h46, 1'b0, 8'b0111_0000, 1'b1, 2);
      idle_hold("ignore_start_no_extra", 8'h46, 1'b0, 12);
   endtask

   task automatic test_reset_mid_run();
      bus.start = 1'b1; bus.op = 3'b000; bus.a = 8'hFF; bus.b = 8'hFF;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b1 || bus.s_a !== 1'b1 || bus.s_cin !== 1'b1)
         begin errors++; $display("FAIL rst_mid pre busy=%b s_a=%b s_cin=%b, want 111", bus.busy, bus.s_a, bus.s_cin); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({bus.busy, bus.done, bus.carry_out, bus.result} !== 11'b0 || {bus.s_a, bus.s_b, bus.s_cin, bus.s_op} !== 6'b0)
         begin errors++; $display("FAIL rst_mid busy=%b done=%b carry=%b result=%h s_op=%b, want all 0", bus.busy, bus.done, bus.carry_out, bus.result, bus.s_op); end
      idle_hold("rst_mid_quiet", 8'h00, 1'b0, 10);
      run_op("rst_mid_fresh", 3'b000, 8'h3C, 8'h0A, 8'h46, 1'b0, 8'b0111_0000, 1'b1, -1);
      idle_hold("rst_mid_fresh_hold", 8'h46, 1'b0, 1);
   endtask

   task automatic test_back_to_back();
      run_op("b2b_first", 3'b000, 8'hF0, 8'h0F, 8'hFF, 1'b0, 8'h00, 1'b1, -1);
      run_op("b2b_second", 3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 8'b0000_0010, 1'b1, -1);
      idle_hold("b2b_hold", 8'h02, 1'b0, 2);
   endtask

   initial begin
      test_reset();
      test_add();
      test_logic();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
